cu_read_command_arbiter: RTL
============================

Name: cu_read_command_arbiter

Overview:
- Sits directly upstream of the vertex cache-reuse read path in the PageRank CSR PULL global CU.
- Collects read commands from NUM_REQUESTORS graph CU clusters, buffers each stream in a small per-requestor FIFO, and round-robin arbitrates them onto the single read command stream.
- Honours downstream almost-full backpressure.
- Tags each issued command with its source index so responses can be routed back.

Parameters:
- NUM_REQUESTORS, 4, number of graph CU command sources; power of two, 2..16.
- CMD_WIDTH, 128, command payload width in bits.
- FIFO_DEPTH, 4, entries per requestor FIFO; power of two, >= 2.
- ID_WIDTH, $clog2(NUM_REQUESTORS), width of the source tag.

Ports:
- clock, input, 1, single clock; all logic is rising-edge.
- rst_in, input, 1, reset; asynchronous, active-high.
- enabled_in, input, 1, issue enable; while low, no command is issued.
- cmd_valid_in, input, NUM_REQUESTORS, per-requestor command valid; one bit per source.
- cmd_payload_in, input, NUM_REQUESTORS*CMD_WIDTH, commands; requestor i occupies bits [i*CMD_WIDTH +: CMD_WIDTH].
- cmd_alfull_out, output, NUM_REQUESTORS, per-requestor FIFO almost-full; requestors must stop sending while high.
- read_buffer_alfull_in, input, 1, downstream read command buffer almost full.
- read_command_valid_out, output, 1, issued command valid.
- read_command_payload_out, output, CMD_WIDTH, issued command.
- read_command_id_out, output, ID_WIDTH, source index of the issued command.
- issued_count_out, output, 32, total commands issued since reset.
- overflow_error_out, output, NUM_REQUESTORS, sticky per-requestor overflow flag.

Behaviour:
- Reset (asynchronous on rst_in high): all FIFOs empty; round-robin pointer = 0; every output = 0.
- Write side: cmd_valid_in[i] high writes payload i into FIFO i on that edge.
  - Occupancy counters are ID-free and have width $clog2(FIFO_DEPTH)+1.
  - Read and write pointers wrap modulo FIFO_DEPTH.
- cmd_alfull_out[i] is registered and equals (occupancy_i >= FIFO_DEPTH-1). It reflects occupancy after the current edge's write and pop.
- Full FIFO: a write arriving when occupancy_i == FIFO_DEPTH is dropped and sets overflow_error_out[i]. The flag clears only on reset.
  - A write and a pop on the same edge at full is not an overflow; occupancy stays FIFO_DEPTH.
- Issue condition per cycle: enabled_in && !read_buffer_alfull_in && at least one FIFO non-empty. Non-empty is sampled on registered occupancy, so a command written at edge N is eligible at edge N+1.
- Arbitration: round-robin starting at pointer p.
  - Grant the lowest index k in order p, p+1, ..., NUM_REQUESTORS-1, 0, ... whose FIFO is non-empty.
  - On a grant, pop FIFO k and set p = (k+1) mod NUM_REQUESTORS.
  - On no grant, p is unchanged.
- Output register: on a grant edge, read_command_valid_out <= 1, payload <= FIFO k head, id <= k, issued_count_out increments. Otherwise valid <= 0 and payload/id hold their last values.
- Latency: write at edge N gives earliest valid_out high after edge N+1, i.e. 2 cycles input to output.
- Throughput: at most 1 command per cycle total.
- Backpressure: read_buffer_alfull_in is sampled on the grant edge. While it is high, no pops occur and valid_out drops the next cycle; in-flight registered output is not retracted.
- enabled_in low: FIFOs still accept writes; no issue occurs; state is preserved.
- issued_count_out wraps from 2^32-1 to 0.
- Reset mid-operation: all buffered commands are discarded; valid_out falls asynchronously with rst_in.
- Ordering: commands from one requestor are issued in arrival order. There is no ordering guarantee across requestors.

Test Plan:
- Reset, then single command: write payload 0xA5 on requestor 2 at edge 0 -> valid_out=1, payload=0xA5, id=2 after edge 1; issued_count_out=1; valid_out=0 next cycle.
- Fairness: all 4 FIFOs hold 2 commands, enabled, no backpressure -> id sequence 0,1,2,3,0,1,2,3 on 8 consecutive cycles; issued_count_out=8.
- Backpressure: read_buffer_alfull_in=1 for 5 cycles with 3 commands queued -> no valid_out during the stall; after release, 3 issues on 3 consecutive cycles in RR order.
- Almost-full/overflow, FIFO_DEPTH=4, enabled_in=0, 5 writes to requestor 1:
  - cmd_alfull_out[1]=1 after the 3rd write.
  - The 5th write is dropped and overflow_error_out[1]=1.
  - After enable, exactly 4 commands issue in order.
- Simultaneous push/pop at full: requestor 0 full, pop granted and write on the same edge -> occupancy stays 4, no overflow flag, FIFO order preserved.
- Reset mid-stream: assert rst_in with 6 commands queued -> all outputs 0 immediately, including issued_count_out; after release, no valid_out without new writes.

Source files
------------

// File: rtl/cu_read_command_arbiter.sv
// Per-requestor command FIFOs with a round-robin arbiter onto one
// tagged read command stream, honouring downstream almost-full.
module cu_read_command_arbiter #(
  parameter int NUM_REQUESTORS = 4,
  parameter int CMD_WIDTH      = 128,
  parameter int FIFO_DEPTH     = 4,
  parameter int ID_WIDTH       = $clog2(NUM_REQUESTORS)
) (
  input  logic                                clock,
  input  logic                                rst_in,
  input  logic                                enabled_in,
  input  logic [NUM_REQUESTORS-1:0]           cmd_valid_in,
  input  logic [NUM_REQUESTORS*CMD_WIDTH-1:0] cmd_payload_in,
  output logic [NUM_REQUESTORS-1:0]           cmd_alfull_out,
  input  logic                                read_buffer_alfull_in,
  output logic                                read_command_valid_out,
  output logic [CMD_WIDTH-1:0]                read_command_payload_out,
  output logic [ID_WIDTH-1:0]                 read_command_id_out,
  output logic [31:0]                         issued_count_out,
  output logic [NUM_REQUESTORS-1:0]           overflow_error_out
);

  localparam int N  = NUM_REQUESTORS;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] ALF  = CW'(FIFO_DEPTH - 1);

  logic [CMD_WIDTH-1:0] mem_q [N][FIFO_DEPTH];

  logic [N-1:0][PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [N-1:0][PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [N-1:0][CW-1:0] occ_q, occ_d;
  logic [N-1:0]         alfull_q, alfull_d;
  logic [N-1:0]         ovf_q, ovf_d;
  logic [N-1:0]         push, pop, nonempty;

  logic [ID_WIDTH-1:0]  rr_q, rr_d;
  logic [ID_WIDTH-1:0]  gnt_id, idx;
  logic                 gnt, issue_ok;

  logic                 valid_q, valid_d;
  logic [CMD_WIDTH-1:0] payload_q, payload_d;
  logic [ID_WIDTH-1:0]  id_q, id_d;
  logic [31:0]          count_q, count_d;

  // Eligibility uses registered occupancy only.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      nonempty[i] = (occ_q[i] != '0);
    end
  end

  // Search from the RR pointer; N is a power of two so the add wraps.
  always_comb begin
    issue_ok = enabled_in && !read_buffer_alfull_in;
    gnt      = 1'b0;
    gnt_id   = '0;
    idx      = '0;
    for (int j = 0; j < N; j++) begin
      idx = rr_q + ID_WIDTH'(j);
      if (issue_ok && !gnt && nonempty[idx]) begin
        gnt    = 1'b1;
        gnt_id = idx;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N; i++) begin
      pop[i]      = gnt && (gnt_id == ID_WIDTH'(i));
      push[i]     = cmd_valid_in[i] && ((occ_q[i] != FULL) || pop[i]);
      occ_d[i]    = occ_q[i] + CW'(push[i]) - CW'(pop[i]);
      wr_ptr_d[i] = wr_ptr_q[i] + PW'(push[i]);
      rd_ptr_d[i] = rd_ptr_q[i] + PW'(pop[i]);
      alfull_d[i] = (occ_d[i] >= ALF);
      ovf_d[i]    = ovf_q[i] | (cmd_valid_in[i] & ~push[i]);
    end
  end

  always_comb begin
    rr_d      = rr_q;
    valid_d   = gnt;
    payload_d = payload_q;
    id_d      = id_q;
    count_d   = count_q;
    if (gnt) begin
      rr_d      = gnt_id + ID_WIDTH'(1);
      payload_d = mem_q[gnt_id][rd_ptr_q[gnt_id]];
      id_d      = gnt_id;
      count_d   = count_q + 32'd1;
    end
  end

  // Storage carries no reset; occupancy alone defines validity.
  always_ff @(posedge clock) begin
    for (int i = 0; i < N; i++) begin
      if (push[i]) begin
        mem_q[i][wr_ptr_q[i]] <= cmd_payload_in[i*CMD_WIDTH +: CMD_WIDTH];
      end
    end
  end

  always_ff @(posedge clock or posedge rst_in) begin
    if (rst_in) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      occ_q     <= '0;
      alfull_q  <= '0;
      ovf_q     <= '0;
      rr_q      <= '0;
      valid_q   <= 1'b0;
      payload_q <= '0;
      id_q      <= '0;
      count_q   <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      occ_q     <= occ_d;
      alfull_q  <= alfull_d;
      ovf_q     <= ovf_d;
      rr_q      <= rr_d;
      valid_q   <= valid_d;
      payload_q <= payload_d;
      id_q      <= id_d;
      count_q   <= count_d;
    end
  end

  assign cmd_alfull_out           = alfull_q;
  assign overflow_error_out       = ovf_q;
  assign read_command_valid_out   = valid_q;
  assign read_command_payload_out = payload_q;
  assign read_command_id_out      = id_q;
  assign issued_count_out         = count_q;

endmodule
